// File: rtl/expression_parser.sv
// Parses "A op B term" from a serial ASCII stream into registered ALU operands and an operator code.
// Outputs register one cycle after the character is sampled. There is no backpressure; every valid character is consumed.
module expression_parser #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] data_a,
  output logic [7:0] data_b,
  output logic [7:0] operation,
  output logic       op_valid,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [2:0] MAXD     = 3'(MAX_DIGITS);

  typedef enum logic [2:0] {IDLE, OPA, OPB0, OPB, ERR} state_t;

  state_t      state_q, state_d;
  logic [11:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [2:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  data_a_q, data_a_d, data_b_q, data_b_d, operation_q, operation_d;
  logic        op_valid_q, op_valid_d, err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        is_digit, is_op, is_term;
  logic [11:0] digit, acc_sel, acc_next;
  logic [2:0]  cnt_sel, cnt_next;
  logic        too_big;

  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) || (rx_data == 8'h2A) ||
               (rx_data == 8'h2F) || (rx_data == 8'h26) || (rx_data == 8'h7C);
    is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    digit    = {8'h00, rx_data[3:0]};
    // One shared multiply-add; only OPA and OPB ever use the result.
    acc_sel  = (state_q == OPB) ? acc_b_q : acc_a_q;
    cnt_sel  = (state_q == OPB) ? cnt_b_q : cnt_a_q;
    acc_next = acc_sel * 12'd10 + digit;
    cnt_next = cnt_sel + 3'd1;
    too_big  = (acc_next > 12'd255) || (cnt_next > MAXD);
  end

  always_comb begin
    state_d     = state_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    op_d        = op_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    operation_d = operation_q;
    op_valid_d  = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    if (rx_valid && rx_data != CH_SPACE) begin
      if (rx_data == CH_ESC) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (is_digit) begin
              acc_a_d = digit;
              cnt_a_d = 3'd1;
              state_d = OPA;
            end else if (!is_term) begin
              err_d = 1'b1; err_code_d = 2'b01; state_d = ERR;
            end
          end
          OPA: begin
            if (is_digit) begin
              if (too_big) begin
                err_d = 1'b1; err_code_d = 2'b10; state_d = ERR;
              end else begin
                acc_a_d = acc_next;
                cnt_a_d = cnt_next;
              end
            end else if (is_op) begin
              op_d    = rx_data;
              state_d = OPB0;
            end else begin
              err_d = 1'b1; err_code_d = 2'b01; state_d = ERR;
            end
          end
          OPB0: begin
            if (is_digit) begin
              acc_b_d = digit;
              cnt_b_d = 3'd1;
              state_d = OPB;
            end else begin
              err_d = 1'b1; err_code_d = 2'b01; state_d = ERR;
            end
          end
          OPB: begin
            if (is_digit) begin
              if (too_big) begin
                err_d = 1'b1; err_code_d = 2'b10; state_d = ERR;
              end else begin
                acc_b_d = acc_next;
                cnt_b_d = cnt_next;
              end
            end else if (is_term) begin
              if (op_q == CH_DIV && acc_b_q == 12'd0) begin
                err_d = 1'b1; err_code_d = 2'b11;
              end else begin
                data_a_d    = acc_a_q[7:0];
                data_b_d    = acc_b_q[7:0];
                operation_d = op_q;
                op_valid_d  = 1'b1;
              end
              state_d = IDLE;
            end else begin
              err_d = 1'b1; err_code_d = 2'b01; state_d = ERR;
            end
          end
          ERR: begin
            if (is_term) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      op_q        <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      operation_q <= '0;
      op_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      op_q        <= op_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      operation_q <= operation_d;
      op_valid_q  <= op_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign operation = operation_q;
  assign op_valid  = op_valid_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_expression_parser.sv
// Directed vector bench for expression_parser: table of expressions plus hand-timed corner sequences.
module tb_expression_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] data_a, data_b, operation;
  logic       op_valid, err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  int n_ops = 0, n_errs = 0, n_both = 0;
  logic [1:0] last_code = 2'b00;

  expression_parser #(.MAX_DIGITS(3)) dut (
    .clock(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .data_a(data_a), .data_b(data_b), .operation(operation),
    .op_valid(op_valid), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Pulses last one full cycle, so sampling on the falling edge sees each exactly once.
  always @(negedge clk) begin
    if (op_valid) n_ops++;
    if (err) begin
      n_errs++;
      last_code = err_code;
    end
    if (op_valid && err) n_both++;
  end

  typedef struct {
    logic [127:0] s;
    int           len;
    int           exp_ops;
    int           exp_errs;
    logic [1:0]   exp_code;
    logic [7:0]   exp_a;
    logic [7:0]   exp_b;
    logic [7:0]   exp_op;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_str(input logic [127:0] s, input int len);
    for (int i = len - 1; i >= 0; i--) send_char(s[8*i +: 8]);
    go_idle();
  endtask

  initial begin
    int ops0, errs0;

    vecs[0]  = '{128'("12+34="), 6, 1, 0, 2'b00, 8'h0C, 8'h22, 8'h2B};
    vecs[1]  = '{128'({"255*255", 8'h0D}), 8, 1, 0, 2'b00, 8'hFF, 8'hFF, 8'h2A};
    vecs[2]  = '{128'("256+1="), 6, 0, 1, 2'b10, 8'hFF, 8'hFF, 8'h2A};
    vecs[3]  = '{128'("7-2="), 4, 1, 0, 2'b00, 8'h07, 8'h02, 8'h2D};
    vecs[4]  = '{128'("9/0="), 4, 0, 1, 2'b11, 8'h07, 8'h02, 8'h2D};
    vecs[5]  = '{128'("1+="), 3, 0, 1, 2'b01, 8'h07, 8'h02, 8'h2D};
    vecs[6]  = '{128'({8'h1B, "1 2 | 3", 8'h1B, "4&5="}), 13, 1, 0, 2'b00, 8'h04, 8'h05, 8'h26};
    vecs[7]  = '{128'("0255="), 5, 0, 1, 2'b10, 8'h04, 8'h05, 8'h26};
    vecs[8]  = '{128'("12=="), 4, 0, 1, 2'b01, 8'h04, 8'h05, 8'h26};
    vecs[9]  = '{128'("="), 1, 0, 0, 2'b00, 8'h04, 8'h05, 8'h26};
    vecs[10] = '{128'("+1="), 3, 0, 1, 2'b01, 8'h04, 8'h05, 8'h26};
    vecs[11] = '{128'("1-2-3="), 6, 0, 1, 2'b01, 8'h04, 8'h05, 8'h26};
    vecs[12] = '{128'("0/5="), 4, 1, 0, 2'b00, 8'h00, 8'h05, 8'h2F};
    vecs[13] = '{128'("999="), 4, 0, 1, 2'b10, 8'h00, 8'h05, 8'h2F};
    vecs[14] = '{128'("  8 | 1 6 ="), 11, 1, 0, 2'b00, 8'h08, 8'h10, 8'h7C};

    // Outputs while reset is held from time zero.
    #12;
    chk("reset data_a", 32'(data_a), 32'h00);
    chk("reset data_b", 32'(data_b), 32'h00);
    chk("reset operation", 32'(operation), 32'h00);
    chk("reset op_valid", 32'(op_valid), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset err_code", 32'(err_code), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      ops0  = n_ops;
      errs0 = n_errs;
      send_str(vecs[v].s, vecs[v].len);
      chk($sformatf("vec%0d op_valid count", v), 32'(n_ops - ops0), 32'(vecs[v].exp_ops));
      chk($sformatf("vec%0d err count", v), 32'(n_errs - errs0), 32'(vecs[v].exp_errs));
      if (vecs[v].exp_errs > 0)
        chk($sformatf("vec%0d err_code", v), 32'(last_code), 32'(vecs[v].exp_code));
      chk($sformatf("vec%0d data_a", v), 32'(data_a), 32'(vecs[v].exp_a));
      chk($sformatf("vec%0d data_b", v), 32'(data_b), 32'(vecs[v].exp_b));
      chk($sformatf("vec%0d operation", v), 32'(operation), 32'(vecs[v].exp_op));
    end

    // Range error must fire on the offending digit itself.
    send_char("2");
    chk("range '2' err", 32'(err), 32'h0);
    send_char("5");
    chk("range '5' err", 32'(err), 32'h0);
    send_char("6");
    chk("range '6' err", 32'(err), 32'h1);
    chk("range '6' err_code", 32'(err_code), 32'h2);
    chk("range '6' op_valid", 32'(op_valid), 32'h0);
    send_char("=");
    chk("range '=' no second err", 32'(err), 32'h0);
    go_idle();

    // Commit pulse appears right after the term is sampled and lasts one cycle.
    send_char("1");
    send_char("+");
    send_char("2");
    chk("pre-term op_valid", 32'(op_valid), 32'h0);
    send_char("=");
    chk("term op_valid", 32'(op_valid), 32'h1);
    chk("term data_a", 32'(data_a), 32'h01);
    go_idle();
    chk("op_valid drops", 32'(op_valid), 32'h0);

    // Reset mid-expression discards the partial parse.
    ops0  = n_ops;
    errs0 = n_errs;
    send_char("9");
    send_char("9");
    send_char("-");
    #3;
    reset = 1'b1;
    #1;
    chk("midreset data_a", 32'(data_a), 32'h00);
    chk("midreset data_b", 32'(data_b), 32'h00);
    chk("midreset operation", 32'(operation), 32'h00);
    chk("midreset op_valid", 32'(op_valid), 32'h0);
    chk("midreset err", 32'(err), 32'h0);
    chk("midreset err_code", 32'(err_code), 32'h0);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_str(128'("3+4="), 4);
    chk("post-reset op count", 32'(n_ops - ops0), 32'h1);
    chk("post-reset err count", 32'(n_errs - errs0), 32'h0);
    chk("post-reset data_a", 32'(data_a), 32'h03);
    chk("post-reset data_b", 32'(data_b), 32'h04);
    chk("post-reset operation", 32'(operation), 32'h2B);

    chk("op_valid and err overlap", 32'(n_both), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
